demux_stream_1ton: RTL and testbench

Parametrised registered 1-to-N stream demultiplexer with valid/ready handshake; next generation of the 1-to-4 combinational demux.
- Routes one input word to a selected output channel (unicast), or to all channels at once (broadcast).
- Each channel has a one-entry output register, so latency is one cycle and back-pressure is handled per channel.
- Out-of-range selects are dropped and counted in an error counter.
- Sits between a single producer and NCH independent consumers.

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_chan_reg.sv | 45 ++++
 rtl/demux_stream_1ton.sv | 96 +++++++++
 tb/tb_demux_stream_1ton.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-N stream demultiplexer.
package demux_pkg;

  localparam logic MODE_UNICAST   = 1'b0;
  localparam logic MODE_BROADCAST = 1'b1;

  // Select width for a given channel count; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry output register for a single demux channel with load/drain handshake.
module demux_chan_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             can_acc_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  assign can_acc_o = ~vld_q | ready_i;

  // A load wins over a drain in the same cycle, keeping full throughput.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (load_i) begin
      vld_d = 1'b1;
      dat_d = data_i;
    end else if (vld_q && ready_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign valid_o = vld_q;
  assign data_o  = dat_q;

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-NCH stream demux: unicast by SEL or broadcast, per-channel back-pressure,
// saturating count of dropped out-of-range selects.
module demux_stream_1ton
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = sel_width(NCH),
  parameter int unsigned ERRW  = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 MODE,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     IN_DATA,
  input  logic [SELW-1:0]      SEL,
  output logic [NCH-1:0]       OUT_VALID,
  input  logic [NCH-1:0]       OUT_READY,
  output logic [NCH*WIDTH-1:0] OUT_DATA,
  output logic [ERRW-1:0]      ERR_CNT
);

  localparam int unsigned NSEL = 1 << SELW;

  logic [NCH-1:0]  can_acc;
  logic [NCH-1:0]  load;
  logic [NSEL-1:0] can_acc_pad;
  logic            sel_ok;
  logic            in_fire;
  logic [ERRW-1:0] err_q, err_d;

  // Pad to the full select range so indexing by SEL is always in bounds.
  always_comb begin
    can_acc_pad            = '1;
    can_acc_pad[NCH-1:0]   = can_acc;
  end

  if (NSEL == NCH) begin : g_sel_pow2
    assign sel_ok = 1'b1;
  end else begin : g_sel_range
    assign sel_ok = (SEL < SELW'(NCH));
  end

  // Out-of-range unicast words are always accepted so they can be dropped.
  always_comb begin
    IN_READY = 1'b1;
    if (MODE == MODE_BROADCAST) begin
      IN_READY = &can_acc;
    end else if (sel_ok) begin
      IN_READY = can_acc_pad[SEL];
    end
  end

  assign in_fire = IN_VALID & IN_READY;

  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      load[i] = in_fire & ((MODE == MODE_BROADCAST) | (sel_ok & (SEL == SELW'(i))));
    end
  end

  always_comb begin
    err_d = err_q;
    if (in_fire && (MODE == MODE_UNICAST) && !sel_ok && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ERR_CNT = err_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    demux_chan_reg #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk_i    (CLK),
      .rst_ni   (RST_N),
      .load_i   (load[i]),
      .data_i   (IN_DATA),
      .ready_i  (OUT_READY[i]),
      .valid_o  (OUT_VALID[i]),
      .data_o   (OUT_DATA[i*WIDTH +: WIDTH]),
      .can_acc_o(can_acc[i])
    );
  end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Scoreboard bench for demux_stream_1ton: a 4-channel instance for routing and back-pressure,
// a 3-channel instance for out-of-range error counting.
module tb_demux_stream_1ton;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        mode, in_valid, in_ready;
  logic [7:0]  in_data;
  logic [1:0]  sel;
  logic [3:0]  out_valid, out_ready;
  logic [31:0] out_data;
  logic [7:0]  err_cnt;

  logic        mode3, in_valid3, in_ready3;
  logic [7:0]  in_data3;
  logic [1:0]  sel3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic [23:0] out_data3;
  logic [7:0]  err_cnt3;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q [4][$];

  always #5 clk = ~clk;

  demux_stream_1ton #(.WIDTH(8), .NCH(4), .ERRW(8)) dut4 (
    .CLK(clk), .RST_N(rst_n), .MODE(mode), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_DATA(in_data), .SEL(sel), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT_DATA(out_data), .ERR_CNT(err_cnt)
  );

  demux_stream_1ton #(.WIDTH(8), .NCH(3), .ERRW(8)) dut3 (
    .CLK(clk), .RST_N(rst_n), .MODE(mode3), .IN_VALID(in_valid3), .IN_READY(in_ready3),
    .IN_DATA(in_data3), .SEL(sel3), .OUT_VALID(out_valid3), .OUT_READY(out_ready3),
    .OUT_DATA(out_data3), .ERR_CNT(err_cnt3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer on dut4 pops and compares the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 4; i++) begin
          if (out_valid[i] && out_ready[i]) begin
            if (exp_q[i].size() == 0) begin
              check($sformatf("unexpected_ch%0d", i), {24'd0, out_data[i*8 +: 8]}, 32'hxxxx_xxxx);
            end else begin
              check($sformatf("data_ch%0d", i), {24'd0, out_data[i*8 +: 8]},
                    {24'd0, exp_q[i].pop_front()});
            end
          end
        end
      end
    end
  end

  // Drive one word on dut4, wait (bounded) for acceptance, record expectation.
  task automatic send(input logic m, input logic [1:0] s, input logic [7:0] d);
    int waited;
    waited   = 0;
    mode     = m;
    sel      = s;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("send_accept", {31'd0, in_ready}, 32'd1);
    if (in_ready) begin
      if (m) begin
        for (int i = 0; i < 4; i++) exp_q[i].push_back(d);
      end else begin
        exp_q[s].push_back(d);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mode     = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    mode = 1'b0; in_valid = 1'b0; in_data = '0; sel = '0; out_ready = 4'b1111;
    mode3 = 1'b0; in_valid3 = 1'b0; in_data3 = '0; sel3 = '0; out_ready3 = 3'b111;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", {28'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_err", {24'd0, err_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unicast to channel 2
    send(1'b0, 2'd2, 8'hA5);
    @(negedge clk);
    check("uni_valid", {28'd0, out_valid}, 32'h4);
    check("uni_data", {24'd0, out_data[23:16]}, 32'hA5);
    check("uni_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Per-channel back-pressure
    out_ready = 4'b1101;
    send(1'b0, 2'd1, 8'h11);
    sel = 2'd1; in_data = 8'h22; in_valid = 1'b1;
    @(negedge clk);
    check("bp_block", {31'd0, in_ready}, 32'd0);
    sel = 2'd3; in_data = 8'h33;
    #1;
    check("bp_other", {31'd0, in_ready}, 32'd1);
    exp_q[3].push_back(8'h33);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_valid", {28'd0, out_valid}, 32'hA);
    check("bp_hold", {24'd0, out_data[15:8]}, 32'h11);
    @(posedge clk); #1;
    out_ready = 4'b1111;
    @(posedge clk); #1;

    // Streaming 8 words to channel 0
    for (int k = 0; k < 8; k++) begin
      mode = 1'b0; sel = 2'd0; in_data = 8'(k); in_valid = 1'b1;
      @(negedge clk);
      check("stream_ready", {31'd0, in_ready}, 32'd1);
      exp_q[0].push_back(8'(k));
      if (k > 0) begin
        check("stream_valid", {31'd0, out_valid[0]}, 32'd1);
        check("stream_order", {24'd0, out_data[7:0]}, k - 1);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_last", {24'd0, out_data[7:0]}, 32'h07);
    @(posedge clk); #1;

    // Broadcast blocked by a full, stalled channel 2
    out_ready = 4'b1011;
    send(1'b0, 2'd2, 8'h44);
    mode = 1'b1; sel = 2'd1; in_data = 8'h3C; in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("bc_block", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 4'b1111;
    @(negedge clk);
    check("bc_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) exp_q[i].push_back(8'h3C);
    @(posedge clk); #1;
    in_valid = 1'b0; mode = 1'b0;
    @(negedge clk);
    check("bc_valid", {28'd0, out_valid}, 32'hF);
    check("bc_data", out_data, 32'h3C3C3C3C);
    check("bc_no_err", {24'd0, err_cnt}, 32'd0);
    @(posedge clk); #1;

    // Out-of-range selects on the 3-channel instance
    for (int k = 0; k < 300; k++) begin
      mode3 = 1'b0; sel3 = 2'd3; in_data3 = 8'(k); in_valid3 = 1'b1;
      @(negedge clk);
      check("err_ready", {31'd0, in_ready3}, 32'd1);
      check("err_no_valid", {29'd0, out_valid3}, 32'd0);
      check("err_count", {24'd0, err_cnt3}, (k > 255) ? 32'd255 : k);
      @(posedge clk); #1;
    end
    in_valid3 = 1'b0;
    @(negedge clk);
    check("err_sat", {24'd0, err_cnt3}, 32'hFF);
    @(posedge clk); #1;
    sel3 = 2'd2; in_data3 = 8'h5A; in_valid3 = 1'b1;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    @(negedge clk);
    check("nch3_valid", {29'd0, out_valid3}, 32'h4);
    check("nch3_data", {24'd0, out_data3[23:16]}, 32'h5A);
    check("nch3_err_hold", {24'd0, err_cnt3}, 32'hFF);
    @(posedge clk); #1;

    // Asynchronous reset with channels 0 and 2 full
    out_ready = 4'b0000;
    send(1'b0, 2'd0, 8'h77);
    send(1'b0, 2'd2, 8'h99);
    @(negedge clk);
    check("pre_rst_valid", {28'd0, out_valid}, 32'h5);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {28'd0, out_valid}, 32'd0);
    check("arst_data", out_data, 32'd0);
    check("arst_err", {24'd0, err_cnt3}, 32'd0);
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 4'b1111;
    send(1'b0, 2'd1, 8'hC3);
    @(negedge clk);
    check("post_rst_valid", {28'd0, out_valid}, 32'h2);
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      check($sformatf("drained_ch%0d", i), exp_q[i].size(), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
